// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline types: skid-buffer state encoding, default counter width
// and the packed per-stage payload structs passed as WIDTH via $bits().
package pipes;

    localparam int unsigned PIPE_CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_MAIN  = 2'b01,
        SKID_BOTH  = 2'b10
    } skid_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_data_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] rs1Val;
        logic [31:0] rs2Val;
        logic [31:0] imm;
        logic [5:0]  op;
    } decode_data_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] aluRes;
        logic [31:0] storeVal;
        logic        memRead;
        logic        memWrite;
        logic        regWrite;
    } execute_data_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] result;
        logic        regWrite;
    } memory_data_t;

    // True when the skid state holds a beat in the output entry.
    function automatic logic skidHasMain(skid_state_t s);
        return (s == SKID_MAIN) || (s == SKID_BOTH);
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous active-low reset; used for
// performance tracing counters.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, holding at the all-ones value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake,
// synchronous flush, optional two-entry skid buffer (registered in_ready)
// and a saturating stall-cycle counter.
module pipe_stage_reg
    import pipes::*;
#(
    parameter int unsigned WIDTH      = 64,
    parameter bit          SKID       = 1'b0,
    parameter bit          CLEAR_DATA = 1'b1,
    parameter int unsigned CNT_W      = PIPE_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    logic stallInc;

    assign stallInc = out_valid && !out_ready;

    sat_counter #(.W(CNT_W)) stallCounter (
        .clk   (clk),
        .reset (reset),
        .inc   (stallInc),
        .count (stall_cnt)
    );

    if (SKID == 1'b0) begin : gSingle

        logic             validQ;
        logic [WIDTH-1:0] dataQ;
        logic             inAccept;
        logic             outAccept;

        assign in_ready  = out_ready || !validQ;
        assign inAccept  = in_valid && in_ready;
        assign outAccept = validQ && out_ready;
        assign out_valid = validQ;
        assign out_data  = dataQ;

        // Single entry: load on in-accept (replacing a leaving beat), empty on out-accept.
        always_ff @(posedge clk) begin
            if (!reset) begin
                validQ <= 1'b0;
                dataQ  <= '0;
            end else if (flush) begin
                validQ <= 1'b0;
                if (CLEAR_DATA) begin
                    dataQ <= '0;
                end
            end else if (inAccept) begin
                validQ <= 1'b1;
                dataQ  <= in_data;
            end else if (outAccept) begin
                validQ <= 1'b0;
                if (CLEAR_DATA) begin
                    dataQ <= '0;
                end
            end
        end

    end else begin : gSkid

        skid_state_t      stateQ;
        skid_state_t      stateD;
        logic [WIDTH-1:0] mainQ;
        logic [WIDTH-1:0] skidQ;
        logic             inReadyQ;
        logic             inAccept;
        logic             outAccept;
        logic             loadMainFromIn;
        logic             loadMainFromSkid;
        logic             loadSkidFromIn;
        logic             clearMain;

        assign out_valid = skidHasMain(stateQ);
        assign out_data  = mainQ;
        assign in_ready  = inReadyQ;
        assign inAccept  = in_valid && inReadyQ;
        assign outAccept = out_valid && out_ready;

        // Next-state and entry-load decisions; unknown encodings fall back to EMPTY.
        always_comb begin
            stateD           = stateQ;
            loadMainFromIn   = 1'b0;
            loadMainFromSkid = 1'b0;
            loadSkidFromIn   = 1'b0;
            clearMain        = 1'b0;
            case (stateQ)
                SKID_EMPTY: begin
                    if (inAccept) begin
                        stateD         = SKID_MAIN;
                        loadMainFromIn = 1'b1;
                    end
                end
                SKID_MAIN: begin
                    if (inAccept && outAccept) begin
                        loadMainFromIn = 1'b1;
                    end else if (inAccept) begin
                        stateD         = SKID_BOTH;
                        loadSkidFromIn = 1'b1;
                    end else if (outAccept) begin
                        stateD    = SKID_EMPTY;
                        clearMain = 1'b1;
                    end
                end
                SKID_BOTH: begin
                    if (outAccept) begin
                        stateD           = SKID_MAIN;
                        loadMainFromSkid = 1'b1;
                    end
                end
                default: begin
                    stateD    = SKID_EMPTY;
                    clearMain = 1'b1;
                end
            endcase
        end

        // State, entries and in_ready register; in_ready is derived from the
        // next state so it is registered yet still reflects this cycle's moves.
        always_ff @(posedge clk) begin
            if (!reset) begin
                stateQ   <= SKID_EMPTY;
                inReadyQ <= 1'b1;
                mainQ    <= '0;
                skidQ    <= '0;
            end else if (flush) begin
                stateQ   <= SKID_EMPTY;
                inReadyQ <= 1'b1;
                if (CLEAR_DATA) begin
                    mainQ <= '0;
                    skidQ <= '0;
                end
            end else begin
                stateQ   <= stateD;
                inReadyQ <= (stateD != SKID_BOTH);
                if (loadMainFromIn) begin
                    mainQ <= in_data;
                end else if (loadMainFromSkid) begin
                    mainQ <= skidQ;
                end else if (clearMain && CLEAR_DATA) begin
                    mainQ <= '0;
                end
                if (loadSkidFromIn) begin
                    skidQ <= in_data;
                end else if (loadMainFromSkid && CLEAR_DATA) begin
                    skidQ <= '0;
                end
            end
        end

    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (single-entry, skid with
// clearing, skid without clearing and 4-bit counter) share one stimulus
// stream and are checked every cycle against a queue-based model.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] in_data;

    logic        r0, r1, r2;
    logic        v0, v1, v2;
    logic [63:0] d0, d1, d2;
    logic [15:0] s0, s1;
    logic [3:0]  s2;

    logic        inReady  [3];
    logic        outValid [3];
    logic [63:0] outData  [3];
    logic [15:0] stallCnt [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(64), .SKID(1'b0), .CLEAR_DATA(1'b1), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(r0), .in_data(in_data),
        .out_valid(v0), .out_ready(out_ready), .out_data(d0), .stall_cnt(s0));

    pipe_stage_reg #(.WIDTH(64), .SKID(1'b1), .CLEAR_DATA(1'b1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(r1), .in_data(in_data),
        .out_valid(v1), .out_ready(out_ready), .out_data(d1), .stall_cnt(s1));

    pipe_stage_reg #(.WIDTH(64), .SKID(1'b1), .CLEAR_DATA(1'b0), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(r2), .in_data(in_data),
        .out_valid(v2), .out_ready(out_ready), .out_data(d2), .stall_cnt(s2));

    assign inReady[0]  = r0;
    assign inReady[1]  = r1;
    assign inReady[2]  = r2;
    assign outValid[0] = v0;
    assign outValid[1] = v1;
    assign outValid[2] = v2;
    assign outData[0]  = d0;
    assign outData[1]  = d1;
    assign outData[2]  = d2;
    assign stallCnt[0] = s0;
    assign stallCnt[1] = s1;
    assign stallCnt[2] = {12'b0, s2};

    // Model: per instance a FIFO of capacity 1 or 2 holding accepted beats.
    int          mSkid  [3] = '{0, 1, 1};
    bit          mClear [3] = '{1'b1, 1'b1, 1'b0};
    int unsigned mMax   [3] = '{65535, 65535, 15};
    int unsigned mCount [3] = '{0, 0, 0};
    logic [63:0] mq     [3][2];
    logic [63:0] mShown [3];
    int unsigned mStall [3] = '{0, 0, 0};
    bit          started = 1'b0;

    function automatic bit expReady(int i);
        if (mSkid[i] != 0) return (mCount[i] < 2);
        return (mCount[i] == 0) || out_ready;
    endfunction

    task automatic check(string name, int i, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d at %0t: got %0h expected %0h", name, i, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin : model
        bit ia;
        bit oa;
        for (int i = 0; i < 3; i++) begin
            ia = in_valid && expReady(i);
            oa = (mCount[i] > 0) && out_ready;
            if (!reset) begin
                mCount[i] = 0;
                mShown[i] = '0;
                mStall[i] = 0;
            end else begin
                if ((mCount[i] > 0) && !out_ready && (mStall[i] < mMax[i])) mStall[i]++;
                if (flush) begin
                    mCount[i] = 0;
                end else begin
                    if (oa) begin
                        mq[i][0] = mq[i][1];
                        mCount[i]--;
                    end
                    if (ia) begin
                        mq[i][mCount[i]] = in_data;
                        mCount[i]++;
                    end
                end
                if (mCount[i] > 0) mShown[i] = mq[i][0];
                else if (mClear[i]) mShown[i] = '0;
            end
        end
        if (!reset) started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                check("out_valid", i, 64'(outValid[i]), 64'(mCount[i] > 0));
                check("out_data",  i, outData[i], mShown[i]);
                check("in_ready",  i, 64'(inReady[i]), 64'(expReady(i)));
                check("stall_cnt", i, 64'(stallCnt[i]), 64'(mStall[i]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 64'hDEAD; out_ready = 1'b0;
        step(); step();
        for (int i = 0; i < 3; i++) begin
            check("rst_valid", i, 64'(outValid[i]), 64'd0);
            check("rst_data",  i, outData[i], 64'd0);
            check("rst_stall", i, 64'(stallCnt[i]), 64'd0);
        end
        reset = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) check("rst_ready", i, 64'(inReady[i]), 64'd1);

        // Streaming 1..4 with out_ready held high.
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1; in_data = 64'(k);
            step();
            check("stream_data",  0, d0, 64'(k));
            check("stream_data",  1, d1, 64'(k));
            check("stream_valid", 1, 64'(v1), 64'd1);
            check("stream_ready", 1, 64'(r1), 64'd1);
        end
        in_valid = 1'b0;
        step();
        check("drain_valid", 0, 64'(v0), 64'd0);
        check("drain_data",  1, d1, 64'd0);
        check("hold_data",   2, d2, 64'd4);

        // Backpressure on the skid buffer.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'd10;
        step();
        check("bp_first", 1, d1, 64'd10);
        in_data = 64'd11;
        step();
        in_data = 64'd12;
        check("bp_full_ready", 1, 64'(r1), 64'd0);
        step(); step();
        out_ready = 1'b1;
        step();
        check("bp_second", 1, d1, 64'd11);
        step();
        check("bp_third", 1, d1, 64'd12);
        in_valid = 1'b0;
        step();
        check("bp_empty", 1, 64'(v1), 64'd0);
        check("bp_stall", 1, 64'(s1), 64'd3);

        // Flush while BOTH holds 5,6 and 7 is offered.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'd5;
        step();
        in_data = 64'd6;
        step();
        check("fl_both_ready", 1, 64'(r1), 64'd0);
        flush = 1'b1; in_data = 64'd7;
        step();
        check("fl_valid", 1, 64'(v1), 64'd0);
        check("fl_data",  1, d1, 64'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            step();
            check("fl_no_beat", 1, 64'(v1), 64'd0);
        end

        // Reset in the middle of BOTH.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'd8;
        step();
        in_data = 64'd9;
        step();
        check("mr_both_ready", 1, 64'(r1), 64'd0);
        reset = 1'b0; in_valid = 1'b0;
        step();
        check("mr_ready", 1, 64'(r1), 64'd1);
        check("mr_valid", 1, 64'(v1), 64'd0);
        reset = 1'b1; out_ready = 1'b1;
        repeat (3) begin
            step();
            check("mr_no_stale", 1, 64'(v1), 64'd0);
        end

        // Stall counter saturation.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'd33;
        step();
        in_valid = 1'b0;
        repeat (20) step();
        check("sat4",   2, 64'(s2), 64'd15);
        check("sat16",  1, 64'(s1), 64'd20);

        // Mixed traffic with occasional flushes.
        out_ready = 1'b1;
        repeat (60) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            flush     = ($urandom_range(0, 15) == 0);
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
